rank3x3_filter: RTL and testbench
=================================

# rank3x3_filter

Parametrised 3×3 rank-order filter for the image-processing pipeline. It accepts one vertical 3-pixel column per valid cycle from the upstream line-buffer stage and keeps a sliding 3-column window. Each accepted column is sorted with a three-input sorting stage, and the filter outputs the window median, minimum, maximum or raw centre pixel, selected per column. It is the generalised successor of the team's three-input sorting stage, adding configurable width, valid tagging, line-start handling and mode selection, and it sits between the line buffers and the output formatter.

## Interface
- DATA_W, 8: pixel width in bits. Unsigned; any value ≥ 1.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  the column on row0/row1/row2 is valid this cycle.
- in_sol  input  1  start of line; qualified by in_valid. The column is the first column of a new line.
- row0  input  DATA_W  top pixel of the column.
- row1  input  DATA_W  middle pixel of the column.
- row2  input  DATA_W  bottom pixel of the column.
- mode  input  2  output select, sampled with the column: 00 median, 01 min, 10 max, 11 raw centre.
- out_valid  output  1  out_data holds a valid result.
- out_data  output  DATA_W  filtered pixel.

## Operation
**Stage S0** (on each edge where in_valid=1):
- The column is sorted combinationally into (max, mid, min) and shifted into window slot w0. Existing slots move w0→w1→w2.
- Raw row1 is shifted through parallel registers r0→r1→r2, so that r1 is the raw centre pixel of the window.
- mode is captured into the S1 pipeline.
- When in_valid=0 the window does not shift.

**Fill counter** (2 bits, saturating at 3):
- An accepted column with in_sol=1 sets fill to 1.
- Otherwise an accepted column increments fill, saturating at 3.
- The tag v1 is set to `in_valid && !in_sol && fill>=2`; otherwise v1 is 0.

**Stage S1** (runs every cycle):
- lo = max(w0.min, w1.min, w2.min)
- md = median(w0.mid, w1.mid, w2.mid)
- hi = min(w0.max, w1.max, w2.max)
- mn = min of all column minima
- mx = max of all column maxima
- ctr = r1
- The tag v2 is set to v1.

**Stage S2** (runs every cycle):
- out_data is selected by the carried mode: median(lo, md, hi), mn, mx or ctr.
- out_valid is set to v2.

**Arithmetic and data rules:**
- All comparisons are unsigned, DATA_W bits wide, with no width growth.
- Ties can be ordered either way; the result is identical.
- Each output corresponds to the window formed by the last three accepted columns of the current line.

## Timing
- **Latency:** a column accepted in cycle n produces its result with out_valid=1 in cycle n+3.
- **Throughput:** one result per accepted column once fill ≥ 2, at full rate with no stalls.
- **No back-pressure:** the downstream stage must always accept the output.
- **Bubbles:** in_valid=0 cycles propagate as out_valid=0 three cycles later. Window contents are preserved across bubbles.
- **Line start:** the first two columns of every line, and the first two columns after reset, give no valid output. in_sol=1 with in_valid=0 is ignored.
- **Mode:** mode is associated with each column independently. Switching mode mid-line affects only results for columns accepted after the switch.
- **Reset** (rst_n=0 at a rising edge):
  - window, raw, fill, pipeline tags, out_valid and out_data are all cleared to 0;
  - in-flight results are discarded;
  - after release, three fresh columns are required; in_sol is not needed for the first line.
- **Reset and in_valid together:** reset wins, and the column is dropped.

## Test plan
- **Basic window:** columns (10,20,30), (40,50,60), (70,80,90) with in_sol on the first column and mode=00 → single out_valid pulse, 3 cycles after the third column, out_data=50. Repeat with mode 01→10, 10→90, 11→50.
- **Impulse noise:** all pixels 100 except row1 of the centre column = 255. mode 00 → 100; mode 10 → 255; mode 11 → 255.
- **Line restart:** stream 5 columns, then raise in_sol on column 6 → out_valid for columns 3–5; none for columns 6–7; valid again from column 8, computed using only columns 6–8.
- **Bubbles:** insert 2 idle cycles between columns 2 and 3 of the basic-window test → out_data=50 at 3 cycles after column 3; out_valid is never high during the gap.
- **Reset mid-stream:** assert rst_n=0 for 1 cycle while two results are in flight → both are lost; outputs are 0 on the next cycle; no out_valid until 3 new columns have been accepted.
- **Width and ties:** DATA_W=10, every pixel 1023 except one pixel = 0 → median 1023, min 0, max 1023. An all-equal window of 7 → 7 in every mode.

Source files
------------

// File: rtl/rank3x3_filter.sv
// rank3x3_filter
// Sliding 3x3 rank-order filter. One vertical 3-pixel column is accepted per
// valid cycle. Each column is sorted on entry, so the window is held as three
// sorted columns. The selected result (median, minimum, maximum or raw centre)
// appears three clock edges after the column that completes the window.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   column on row0..row2 is valid this cycle
//   in_sol     start of line, qualified by in_valid
//   row0..2    top / middle / bottom pixel of the column (DATA_W, unsigned)
//   mode       00 median, 01 min, 10 max, 11 raw centre (travels with column)
//   out_valid  out_data holds a valid result
//   out_data   filtered pixel
module rank3x3_filter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sol,
  input  logic [DATA_W-1:0] row0,
  input  logic [DATA_W-1:0] row1,
  input  logic [DATA_W-1:0] row2,
  input  logic [1:0]        mode,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [1:0] MODE_MED = 2'b00;
  localparam logic [1:0] MODE_MIN = 2'b01;
  localparam logic [1:0] MODE_MAX = 2'b10;

  function automatic logic [DATA_W-1:0] f_min(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  // Median of three: the larger of (smaller pair element) and
  // (smaller of larger pair element and c).
  function automatic logic [DATA_W-1:0] f_med3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
    return f_max(f_min(a, b), f_min(f_max(a, b), c));
  endfunction

  // ---------------------------------------------------------------------------
  // S0: sort incoming column, shift window, raw centre line, fill tracking
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_col_max;
  logic [DATA_W-1:0] w_col_mid;
  logic [DATA_W-1:0] w_col_min;

  always_comb begin
    w_col_max = f_max(f_max(row0, row1), row2);
    w_col_mid = f_med3(row0, row1, row2);
    w_col_min = f_min(f_min(row0, row1), row2);
  end

  // Slot 0 is the newest column, slot 2 the oldest.
  logic [DATA_W-1:0] r_wmax [0:2];
  logic [DATA_W-1:0] r_wmid [0:2];
  logic [DATA_W-1:0] r_wmin [0:2];
  // Raw middle pixels of the two newest columns; r_raw1 is the window centre.
  // The oldest raw pixel never reaches an output, so it is not stored.
  logic [DATA_W-1:0] r_raw0;
  logic [DATA_W-1:0] r_raw1;
  logic [1:0]        r_fill;
  logic              r_v1;
  logic [1:0]        r_mode1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_wmax[i] <= '0;
        r_wmid[i] <= '0;
        r_wmin[i] <= '0;
      end
      r_raw0  <= '0;
      r_raw1  <= '0;
      r_fill  <= 2'd0;
      r_v1    <= 1'b0;
      r_mode1 <= 2'b00;
    end else begin
      // The tag looks at the fill count before this column is counted:
      // two earlier columns of the same line must already be present.
      r_v1 <= in_valid && !in_sol && (r_fill >= 2'd2);
      if (in_valid) begin
        r_wmax[0] <= w_col_max;
        r_wmid[0] <= w_col_mid;
        r_wmin[0] <= w_col_min;
        for (int i = 1; i < 3; i++) begin
          r_wmax[i] <= r_wmax[i-1];
          r_wmid[i] <= r_wmid[i-1];
          r_wmin[i] <= r_wmin[i-1];
        end
        r_raw0  <= row1;
        r_raw1  <= r_raw0;
        r_mode1 <= mode;
        if (in_sol) begin
          r_fill <= 2'd1;
        end else if (r_fill != 2'd3) begin
          r_fill <= r_fill + 2'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: rank statistics over the three sorted columns
  // ---------------------------------------------------------------------------
  // The 3x3 median equals median(max of minima, median of mids, min of maxima).
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_md;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_mn;
  logic [DATA_W-1:0] r_mx;
  logic [DATA_W-1:0] r_ctr;
  logic              r_v2;
  logic [1:0]        r_mode2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lo    <= '0;
      r_md    <= '0;
      r_hi    <= '0;
      r_mn    <= '0;
      r_mx    <= '0;
      r_ctr   <= '0;
      r_v2    <= 1'b0;
      r_mode2 <= 2'b00;
    end else begin
      r_lo    <= f_max(f_max(r_wmin[0], r_wmin[1]), r_wmin[2]);
      r_md    <= f_med3(r_wmid[0], r_wmid[1], r_wmid[2]);
      r_hi    <= f_min(f_min(r_wmax[0], r_wmax[1]), r_wmax[2]);
      r_mn    <= f_min(f_min(r_wmin[0], r_wmin[1]), r_wmin[2]);
      r_mx    <= f_max(f_max(r_wmax[0], r_wmax[1]), r_wmax[2]);
      r_ctr   <= r_raw1;
      r_v2    <= r_v1;
      r_mode2 <= r_mode1;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: output select
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;

  always_comb begin
    w_sel = r_ctr;
    case (r_mode2)
      MODE_MED: w_sel = f_med3(r_lo, r_md, r_hi);
      MODE_MIN: w_sel = r_mn;
      MODE_MAX: w_sel = r_mx;
      default:  w_sel = r_ctr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_data  <= w_sel;
      r_out_valid <= r_v2;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rank3x3_filter.sv
// tb_rank3x3_filter
// Directed bench for rank3x3_filter. Two instances share the stimulus: one at
// the default 8-bit width (sees the low 8 bits of each pixel) and one at 10
// bits. Expected results are hand-computed and queued with their due cycle;
// a monitor per instance pops them whenever out_valid is seen.
module tb_rank3x3_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_sol;
  logic [9:0] row0, row1, row2;
  logic [1:0] mode;
  logic       out_valid8;
  logic [7:0] out_data8;
  logic       out_valid10;
  logic [9:0] out_data10;

  always #5 clk = ~clk;

  rank3x3_filter u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sol    (in_sol),
    .row0      (row0[7:0]),
    .row1      (row1[7:0]),
    .row2      (row2[7:0]),
    .mode      (mode),
    .out_valid (out_valid8),
    .out_data  (out_data8)
  );

  rank3x3_filter #(.DATA_W(10)) u_dut10 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sol    (in_sol),
    .row0      (row0),
    .row1      (row1),
    .row2      (row2),
    .mode      (mode),
    .out_valid (out_valid10),
    .out_data  (out_data10)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int    due;
    int    data;
    string tag;
  } exp_t;

  exp_t q8[$];
  exp_t q10[$];
  exp_t e8, e10;

  always @(negedge clk) begin
    if (out_valid10) begin
      if (q10.size() == 0) begin
        check("spurious_valid10", out_valid10, 0);
      end else begin
        e10 = q10.pop_front();
        $display("out w10 %s cyc=%0d data=%0d exp=%0d", e10.tag, cyc, out_data10, e10.data);
        check({e10.tag, "_data10"}, out_data10, e10.data);
        check({e10.tag, "_cyc10"}, cyc, e10.due);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid8) begin
      if (q8.size() == 0) begin
        check("spurious_valid8", out_valid8, 0);
      end else begin
        e8 = q8.pop_front();
        $display("out w8  %s cyc=%0d data=%0d exp=%0d", e8.tag, cyc, out_data8, e8.data & 255);
        check({e8.tag, "_data8"}, out_data8, e8.data & 255);
        check({e8.tag, "_cyc8"}, cyc, e8.due);
      end
    end
  end

  // Present one column; if it completes a window, queue the expected result,
  // due two edges after the accepting edge.
  task automatic send(input bit sol, input int a, input int b, input int c,
                      input logic [1:0] m, input bit exp_on, input int exp_val,
                      input string tag);
    exp_t e;
    in_valid = 1'b1;
    in_sol   = sol;
    row0     = a[9:0];
    row1     = b[9:0];
    row2     = c[9:0];
    mode     = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sol   = 1'b0;
    if (exp_on) begin
      e.due  = cyc + 2;
      e.data = exp_val;
      e.tag  = tag;
      q8.push_back(e);
      q10.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic basic(input logic [1:0] m, input int exp_val, input string tag);
    send(1, 10, 20, 30, m, 0, 0, tag);
    send(0, 40, 50, 60, m, 0, 0, tag);
    send(0, 70, 80, 90, m, 1, exp_val, tag);
  endtask

  task automatic impulse(input logic [1:0] m, input int exp_val, input string tag);
    send(1, 100, 100, 100, m, 0, 0, tag);
    send(0, 100, 255, 100, m, 0, 0, tag);
    send(0, 100, 100, 100, m, 1, exp_val, tag);
  endtask

  task automatic wide(input logic [1:0] m, input int exp_val, input string tag);
    send(1, 0,    1023, 1023, m, 0, 0, tag);
    send(0, 1023, 1023, 1023, m, 0, 0, tag);
    send(0, 1023, 1023, 1023, m, 1, exp_val, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sol   = 1'b0;
    row0     = '0;
    row1     = '0;
    row2     = '0;
    mode     = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid10", out_valid10, 0);
    check("reset_data10",  out_data10,  0);
    check("reset_valid8",  out_valid8,  0);
    check("reset_data8",   out_data8,   0);
    rst_n = 1'b1;

    // Basic window, all four modes back to back
    basic(2'b00, 50, "basic_med");
    basic(2'b01, 10, "basic_min");
    basic(2'b10, 90, "basic_max");
    basic(2'b11, 50, "basic_raw");

    // Impulse noise on the centre pixel
    impulse(2'b00, 100, "impulse_med");
    impulse(2'b10, 255, "impulse_max");
    impulse(2'b11, 255, "impulse_raw");
    impulse(2'b01, 100, "impulse_min");

    // Line restart with uniform columns; a lone in_sol without in_valid is ignored
    send(1, 10, 10, 10, 2'b00, 0, 0,  "restart");
    send(0, 20, 20, 20, 2'b00, 0, 0,  "restart");
    send(0, 30, 30, 30, 2'b00, 1, 20, "restart_c3");
    send(0, 5,  5,  5,  2'b00, 1, 20, "restart_c4");
    in_sol = 1'b1;
    @(posedge clk);
    #1;
    in_sol = 1'b0;
    send(0, 40,  40,  40,  2'b00, 1, 30, "restart_c5");
    send(1, 200, 200, 200, 2'b00, 0, 0,  "restart");
    send(0, 1,   1,   1,   2'b00, 0, 0,  "restart");
    send(0, 3,   3,   3,   2'b00, 1, 3,  "restart_c8");
    send(0, 2,   2,   2,   2'b01, 1, 1,  "restart_c9_min");

    // Bubbles between columns 2 and 3
    send(1, 10, 20, 30, 2'b00, 0, 0, "bubble");
    send(0, 40, 50, 60, 2'b00, 0, 0, "bubble");
    idle(2);
    send(0, 70, 80, 90, 2'b00, 1, 50, "bubble");
    idle(4);

    // Width: one zero pixel among 1023s
    wide(2'b00, 1023, "wide_med");
    wide(2'b01, 0,    "wide_min");
    wide(2'b10, 1023, "wide_max");
    wide(2'b11, 1023, "wide_raw");

    // Reset mid-stream with two results in flight and a column under reset
    send(1, 1,  2,  3,  2'b00, 0, 0, "lost");
    send(0, 4,  5,  6,  2'b00, 0, 0, "lost");
    send(0, 7,  8,  9,  2'b00, 0, 0, "lost");
    send(0, 10, 11, 12, 2'b00, 0, 0, "lost");
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_sol   = 1'b0;
    row0     = 10'd200;
    row1     = 10'd200;
    row2     = 10'd200;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("midreset_valid10", out_valid10, 0);
    check("midreset_data10",  out_data10,  0);
    check("midreset_valid8",  out_valid8,  0);
    check("midreset_data8",   out_data8,   0);

    // Fresh line after reset without in_sol; all-equal window in every mode
    send(0, 7, 7, 7, 2'b00, 0, 0, "tie");
    send(0, 7, 7, 7, 2'b00, 0, 0, "tie");
    send(0, 7, 7, 7, 2'b00, 1, 7, "tie_med");
    send(0, 7, 7, 7, 2'b01, 1, 7, "tie_min");
    send(0, 7, 7, 7, 2'b10, 1, 7, "tie_max");
    send(0, 7, 7, 7, 2'b11, 1, 7, "tie_raw");

    idle(6);
    check("drain10", q10.size(), 0);
    check("drain8",  q8.size(),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
